// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle restoring radix-2 divider with its control FSM,
// sitting in the execute stage for DIV/DIVU.  It produces one quotient bit per
// clock, holds the pipeline through the hazard unit while it iterates and
// hands the quotient/remainder to LO/HI in the DONE cycle.
//
// Handshake: start is a level held by the E stage while stall is high.  The
// request is accepted on the edge where state is IDLE, start=1 and cancel=0.
// done is a single-cycle pulse in DONE; stall is low in that cycle, so the
// pipeline advances exactly when quotient/remainder are valid.
//
// Ports:
//   clka        clock, rising edge
//   rst         synchronous active-high reset
//   start       divide request (level)
//   signed_div  1 = DIV (signed), 0 = DIVU; sampled with start
//   cancel      E-stage flush; aborts an operation in progress
//   a, b        dividend / divisor
//   stall       freeze F/D/E
//   busy        state is RUN
//   done        one-cycle result-valid pulse
//   quotient    result to LO
//   remainder   result to HI
module div_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clka,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic             cancel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // dvd_q starts as |a| and fills with quotient bits from the LSB as it shifts.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;

  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH:0]   shifted, diff;
  logic             ge;
  logic [WIDTH-1:0] rem_nx, dvd_nx;

  // Magnitudes at WIDTH bits; the most negative value maps onto itself and
  // is then handled as an unsigned magnitude.
  always_comb begin
    a_abs = (signed_div && a[WIDTH-1]) ? -a : a;
    b_abs = (signed_div && b[WIDTH-1]) ? -b : b;
  end

  // One restoring step, compared and subtracted at WIDTH+1 bits.
  always_comb begin
    shifted = {rem_q, dvd_q[WIDTH-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = (shifted >= {1'b0, dvs_q});
    rem_nx  = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_nx  = {dvd_q[WIDTH-2:0], ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    case (state_q)
      IDLE: begin
        if (start && !cancel) begin
          state_d = RUN;
          cnt_d   = '0;
          dvd_d   = a_abs;
          dvs_d   = b_abs;
          rem_d   = '0;
          negq_d  = signed_div && (a[WIDTH-1] != b[WIDTH-1]);
          negr_d  = signed_div && a[WIDTH-1];
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (dvs_q == '0) begin
          // Divide by zero: all-ones quotient, remainder is the raw dividend.
          // Re-applying the dividend sign to |a| reproduces a exactly.
          state_d = DONE;
          quo_d   = '1;
          rmd_d   = negr_q ? -dvd_q : dvd_q;
        end else begin
          rem_d = rem_nx;
          dvd_d = dvd_nx;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) begin
            state_d = DONE;
            quo_d   = negq_q ? -dvd_nx : dvd_nx;
            rmd_d   = negr_q ? -rem_nx : rem_nx;
          end
        end
      end
      DONE: begin
        // The requesting instruction leaves E on this edge; start is ignored.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clka) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
    end
  end

  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    stall     = ((state_q == IDLE) && start && !cancel) || (state_q == RUN);
    quotient  = quo_q;
    remainder = rmd_q;
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Bench for div_sequencer: directed and random divides, cancel, mid-run reset
// and back-to-back requests.  Expected {quotient, remainder} pairs are pushed
// when a request is driven and popped by a monitor on every done pulse.
module tb_div_sequencer;

  localparam int W = 32;

  logic         clka = 1'b0;
  logic         rst;
  logic         start;
  logic         signed_div;
  logic         cancel;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         stall;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_res;
  int n_cmp = 0;
  int n_err = 0;

  div_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clka       (clka),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .cancel     (cancel),
    .a          (a),
    .b          (b),
    .stall      (stall),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clka = ~clka;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [2*W-1:0] got,
                       input logic [2*W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: magnitudes, unsigned divide, then sign fix-up.
  function automatic logic [2*W-1:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic sg);
    logic sa, sb;
    logic [W-1:0] ax, ay, q, r;
    if (y == '0) return {{W{1'b1}}, x};
    sa = sg & x[W-1];
    sb = sg & y[W-1];
    ax = sa ? (~x + 1) : x;
    ay = sb ? (~y + 1) : y;
    q  = ax / ay;
    r  = ax % ay;
    if (sa != sb) q = ~q + 1;
    if (sa) r = ~r + 1;
    return {q, r};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clka) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {quotient, remainder}, '0);
      end else begin
        logic [2*W-1:0] e;
        e = exp_q.pop_front();
        check("quotient", {{W{1'b0}}, quotient}, {{W{1'b0}}, e[2*W-1:W]});
        check("remainder", {{W{1'b0}}, remainder}, {{W{1'b0}}, e[W-1:0]});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1 just after the accepting edge; returns at posedge+1
  // after the cycle following done.
  task automatic wait_done(input int exp_lat);
    int lat;
    lat = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clka);
      if (done) begin
        lat = i;
        break;
      end
      @(posedge clka); #1;
    end
    if (lat == 0) begin
      check("done_timeout", 0, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
    end else begin
      check("latency", lat, exp_lat);
      check("stall_in_done", stall, 0);
    end
    @(posedge clka); #1;
    @(negedge clka);
    check("done_one_cycle", done, 0);
    @(posedge clka); #1;
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic sg);
    logic [2*W-1:0] e;
    e = model(ta, tb_v, sg);
    exp_q.push_back(e);
    a = ta; b = tb_v; signed_div = sg; start = 1'b1;
    @(negedge clka);
    check("accept_stall", stall, 1);
    @(posedge clka); #1;
    start = 1'b0;
    wait_done((tb_v == '0) ? 2 : 33);
    last_res = e;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int gap;
    rst = 1'b1; start = 1'b0; signed_div = 1'b0; cancel = 1'b0;
    a = '0; b = '0; last_res = '0;
    repeat (3) @(posedge clka);
    #1 rst = 1'b0;
    @(negedge clka);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    @(posedge clka); #1;

    // directed
    run_op(32'd100, 32'd7, 1'b0);
    run_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFF_FFFE, 1'b1);
    run_op(32'h1234_5678, 32'd0, 1'b0);
    run_op(32'h8765_4321, 32'd0, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(32'd5, 32'd9, 1'b0);

    // random
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 1000)) : W'($urandom);
      run_op(ra, rb, 1'($urandom_range(0, 1)));
    end

    // cancel at RUN iteration 10
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clka); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clka); #1;
    end
    cancel = 1'b1;
    @(negedge clka);
    check("cancel_busy_before", busy, 1);
    @(posedge clka); #1;
    cancel = 1'b0;
    @(negedge clka);
    check("cancel_busy", busy, 0);
    check("cancel_stall", stall, 0);
    check("cancel_done", done, 0);
    check("cancel_hold_q", quotient, last_res[2*W-1:W]);
    check("cancel_hold_r", remainder, last_res[W-1:0]);
    @(posedge clka); #1;
    run_op(32'd9, 32'd3, 1'b0);

    // reset at RUN iteration 20 with start held through it
    a = 32'hDEAD_BEEF; b = 32'h0000_1234; signed_div = 1'b1; start = 1'b1;
    @(posedge clka); #1;
    repeat (19) begin
      @(posedge clka); #1;
    end
    rst = 1'b1;
    @(posedge clka); #1;
    rst = 1'b0;
    @(negedge clka);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_stall", stall, 1);
    exp_q.push_back(model(32'hDEAD_BEEF, 32'h0000_1234, 1'b1));
    @(posedge clka); #1;
    start = 1'b0;
    wait_done(33);

    // back-to-back with start held continuously
    exp_q.push_back(model(32'd100, 32'd7, 1'b0));
    a = 32'd100; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    @(posedge clka); #1;
    gap = 0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clka);
      if (done) begin
        gap = i;
        break;
      end
      @(posedge clka); #1;
    end
    check("b2b_first_latency", gap, 33);
    check("b2b_stall_in_done", stall, 0);
    a = 32'd50; b = 32'd5;
    exp_q.push_back(model(32'd50, 32'd5, 1'b0));
    @(posedge clka); #1;
    @(negedge clka);
    check("b2b_idle_stall", stall, 1);
    check("b2b_idle_busy", busy, 0);
    gap = 1;
    for (int i = 0; i < 60; i++) begin
      @(posedge clka); #1;
      @(negedge clka);
      gap++;
      if (done) break;
    end
    start = 1'b0;
    check("b2b_done_gap", gap, 34);
    @(posedge clka); #1;
    @(negedge clka);
    check("b2b_no_third", busy, 0);
    repeat (3) @(posedge clka);

    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
